// File: rtl/eq_sweep_pkg.sv
// Shared types and defaults for the equalizer tap sweep: FSM state encoding,
// the initial "worst possible" opening and the parameter defaults.
package eq_sweep_pkg;

   typedef enum logic [2:0] {
      IDLE,
      APPLY,
      SETTLE,
      FLUSH,
      MEASURE,
      NEXT,
      FINISH
   } sweep_state_t;

   localparam real INIT_BEST = -1.0e30;

   localparam int DEF_TAP_BITS       = 4;
   localparam int DEF_TAP_MAX        = 15;
   localparam int DEF_SETTLE_CYCLES  = 16;
   localparam int DEF_TIMEOUT_CYCLES = 1024;

   // Counter width able to hold the larger of two load values (value-1).
   function automatic int timer_width(input int a, input int b);
      int m;
      m = (a > b) ? a : b;
      return (m < 2) ? 1 : $clog2(m);
   endfunction

endpackage

// File: rtl/eq_wait_timer.sv
// Loadable down-counter shared by the settle wait and the measurement timeout.
// Holds at zero; expired is high whenever the count is zero.
module eq_wait_timer #(
   parameter int W = 10
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_value,
   output logic         expired
);

   logic [W-1:0] count_reg;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         count_reg <= '0;
      end else if (load) begin
         count_reg <= load_value;
      end else if (count_reg != '0) begin
         count_reg <= count_reg - W'(1);
      end
   end

   assign expired = (count_reg == '0);

endmodule

// File: rtl/eq_tap_sweep.sv
// Sweeps TX FFE tap codes 0..TAP_MAX, measures the eye opening for each and
// keeps the best one. Optional feature macro: EQ_SWEEP_AVG_EN (average two reads).
module eq_tap_sweep
   import eq_sweep_pkg::*;
#(
   parameter int TAP_BITS       = DEF_TAP_BITS,
   parameter int TAP_MAX        = DEF_TAP_MAX,
   parameter int SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                start,
   input  real                 opening,
   input  logic                opening_ready,
   output logic [TAP_BITS-1:0] tap_code,
   output logic                busy,
   output logic                done,
   output logic [TAP_BITS-1:0] best_code,
   output real                 best_opening,
   output logic                timeout_err
);

   localparam int CNT_W = timer_width(SETTLE_CYCLES, TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] SETTLE_LOAD  = CNT_W'((SETTLE_CYCLES  > 0) ? SETTLE_CYCLES  - 1 : 0);
   localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
   localparam logic [TAP_BITS-1:0] LAST_CODE = TAP_BITS'(TAP_MAX);

   sweep_state_t        state_reg, state_next;
   logic [TAP_BITS-1:0] code_reg, code_next;
   logic [TAP_BITS-1:0] tap_code_reg, tap_code_next;
   logic [TAP_BITS-1:0] best_code_reg, best_code_next;
   real                 best_opening_reg, best_opening_next;
   real                 meas_reg, meas_next;
   logic                timeout_err_reg, timeout_err_next;
   logic                flush_first_reg, flush_first_next;
`ifdef EQ_SWEEP_AVG_EN
   real                 first_val_reg, first_val_next;
   logic                avg_phase_reg, avg_phase_next;
`endif

   logic             timer_load;
   logic [CNT_W-1:0] timer_value;
   logic             timer_expired;

   eq_wait_timer #(
      .W(CNT_W)
   ) u_timer (
      .clock      (clock),
      .reset      (reset),
      .load       (timer_load),
      .load_value (timer_value),
      .expired    (timer_expired)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_reg        <= IDLE;
         code_reg         <= '0;
         tap_code_reg     <= '0;
         best_code_reg    <= '0;
         best_opening_reg <= 0.0;
         meas_reg         <= 0.0;
         timeout_err_reg  <= 1'b0;
         flush_first_reg  <= 1'b0;
`ifdef EQ_SWEEP_AVG_EN
         first_val_reg    <= 0.0;
         avg_phase_reg    <= 1'b0;
`endif
      end else begin
         state_reg        <= state_next;
         code_reg         <= code_next;
         tap_code_reg     <= tap_code_next;
         best_code_reg    <= best_code_next;
         best_opening_reg <= best_opening_next;
         meas_reg         <= meas_next;
         timeout_err_reg  <= timeout_err_next;
         flush_first_reg  <= flush_first_next;
`ifdef EQ_SWEEP_AVG_EN
         first_val_reg    <= first_val_next;
         avg_phase_reg    <= avg_phase_next;
`endif
      end
   end

   always_comb begin
      state_next        = state_reg;
      code_next         = code_reg;
      tap_code_next     = tap_code_reg;
      best_code_next    = best_code_reg;
      best_opening_next = best_opening_reg;
      meas_next         = meas_reg;
      timeout_err_next  = timeout_err_reg;
      timer_load        = 1'b0;
      timer_value       = '0;
`ifdef EQ_SWEEP_AVG_EN
      first_val_next    = first_val_reg;
      avg_phase_next    = avg_phase_reg;
`endif

      case (state_reg)
         IDLE: begin
            if (start) begin
               code_next         = '0;
               best_code_next    = '0;
               best_opening_next = INIT_BEST;
               timeout_err_next  = 1'b0;
               state_next        = APPLY;
            end
         end
         APPLY: begin
            tap_code_next = code_reg;
            timer_load    = 1'b1;
            timer_value   = SETTLE_LOAD;
            state_next    = SETTLE;
         end
         SETTLE: begin
            if (timer_expired) begin
               timer_load  = 1'b1;
               timer_value = TIMEOUT_LOAD;
               state_next  = FLUSH;
            end
         end
         FLUSH: begin
            // The first accepted pulse covers a window that straddled the tap change.
            if (opening_ready && !flush_first_reg) begin
               timer_load  = 1'b1;
               timer_value = TIMEOUT_LOAD;
               state_next  = MEASURE;
            end else if (timer_expired) begin
               timeout_err_next = 1'b1;
               state_next       = FINISH;
            end
         end
         MEASURE: begin
            if (opening_ready) begin
`ifdef EQ_SWEEP_AVG_EN
               if (!avg_phase_reg) begin
                  first_val_next = opening;
                  avg_phase_next = 1'b1;
                  timer_load     = 1'b1;
                  timer_value    = TIMEOUT_LOAD;
               end else begin
                  meas_next      = (first_val_reg + opening) * 0.5;
                  avg_phase_next = 1'b0;
                  state_next     = NEXT;
               end
`else
               meas_next  = opening;
               state_next = NEXT;
`endif
            end else if (timer_expired) begin
               timeout_err_next = 1'b1;
               state_next       = FINISH;
`ifdef EQ_SWEEP_AVG_EN
               avg_phase_next   = 1'b0;
`endif
            end
         end
         NEXT: begin
            // Strict compare: on a tie the earlier (lower) code is kept.
            if (meas_reg > best_opening_reg) begin
               best_code_next    = code_reg;
               best_opening_next = meas_reg;
            end
            if (code_reg == LAST_CODE) begin
               state_next = FINISH;
            end else begin
               code_next  = code_reg + TAP_BITS'(1);
               state_next = APPLY;
            end
         end
         FINISH: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase

      // Park the tap on the winner in the same cycle done is raised.
      if (state_next == FINISH) begin
         tap_code_next = best_code_next;
      end
   end

   assign flush_first_next = (state_next == FLUSH) && (state_reg != FLUSH);

   assign tap_code     = tap_code_reg;
   assign busy         = (state_reg != IDLE) && (state_reg != FINISH);
   assign done         = (state_reg == FINISH);
   assign best_code    = best_code_reg;
   assign best_opening = best_opening_reg;
   assign timeout_err  = timeout_err_reg;

endmodule

// File: tb/tb_eq_tap_sweep.sv
// Directed bench for eq_tap_sweep: drives the eye-measurement handshake on a
// fixed per-code timeline and checks sweep results against hand-computed values.
module tb_eq_tap_sweep;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       start = 1'b0;
   logic       opening_ready = 1'b0;
   real        opening = 0.0;
   logic [3:0] tap_code;
   logic       busy;
   logic       done;
   logic [3:0] best_code;
   real        best_opening;
   logic       timeout_err;

   int  total = 0;
   int  bad = 0;
   int  done_cnt = 0;
   real tbl_a [16];
   real tbl_b [16];

`ifdef EQ_SWEEP_AVG_EN
   localparam int CODE_CYCLES = 22;
`else
   localparam int CODE_CYCLES = 21;
`endif

   eq_tap_sweep dut (
      .clock         (clock),
      .reset         (reset),
      .start         (start),
      .opening       (opening),
      .opening_ready (opening_ready),
      .tap_code      (tap_code),
      .busy          (busy),
      .done          (done),
      .best_code     (best_code),
      .best_opening  (best_opening),
      .timeout_err   (timeout_err)
   );

   always #5 clock = ~clock;

   always @(posedge clock) begin
      if (done) done_cnt <= done_cnt + 1;
   end

   task automatic chk(input string tag, input real got, input real exp);
      total++;
      if ((got - exp > 1.0e-6) || (exp - got > 1.0e-6)) begin
         bad++;
         $display("FAIL %s: got %g expected %g", tag, got, exp);
      end
   endtask

   // Called at a negedge in IDLE; returns at the negedge of the first APPLY cycle.
   task automatic sweep_start(input bit noisy);
      start = 1'b1;
      opening_ready = noisy;
      opening = noisy ? 9.99 : 0.0;
      @(negedge clock);
      start = 1'b0;
      opening_ready = 1'b0;
      opening = 0.0;
   endtask

   // One code: APPLY(0) SETTLE(1..16) FLUSH(17 ignored, 18 discarded) MEASURE(19[,20]) NEXT.
   task automatic do_code(input int c, input real va, input real vb, input bit noisy);
      for (int i = 0; i < CODE_CYCLES; i++) begin
         opening_ready = 1'b0;
         opening = 0.0;
         if (i == 1) chk($sformatf("tap_code_c%0d", c), real'(tap_code), real'(c));
         if (noisy && (i == 5 || i == 17 || i == 18)) begin
            opening_ready = 1'b1;
            opening = 9.99;
         end else if (i == 18) begin
            opening_ready = 1'b1;
            opening = 0.0;
         end else if (i == 19) begin
            opening_ready = 1'b1;
            opening = va;
         end else if (i == 20 && CODE_CYCLES == 22) begin
            opening_ready = 1'b1;
            opening = vb;
         end
         @(negedge clock);
      end
      opening_ready = 1'b0;
   endtask

   task automatic run_codes(input int last, input bit noisy);
      for (int c = 0; c <= last; c++) do_code(c, tbl_a[c], tbl_b[c], noisy);
   endtask

   task automatic wait_done(input int limit);
      bit got;
      got = 1'b0;
      for (int i = 0; i < limit; i++) begin
         if (done) begin
            got = 1'b1;
            break;
         end
         @(negedge clock);
      end
      chk("done_seen", real'(got), 1.0);
   endtask

   task automatic check_result(input string name, input int code, input real open, input bit to);
      chk({name, "_best_code"}, real'(best_code), real'(code));
      chk({name, "_best_open"}, best_opening, open);
      chk({name, "_tap_code"}, real'(tap_code), real'(code));
      chk({name, "_timeout"}, real'(timeout_err), real'(to));
      chk({name, "_busy_fin"}, real'(busy), 0.0);
      @(negedge clock);
      chk({name, "_done_pulse"}, real'(done), 0.0);
      $display("sweep %s: best_code=%0d best_opening=%g timeout_err=%0b", name, best_code, best_opening, timeout_err);
      repeat (3) @(negedge clock);
   endtask

   task automatic check_reset(input string name);
      chk({name, "_tap"}, real'(tap_code), 0.0);
      chk({name, "_busy"}, real'(busy), 0.0);
      chk({name, "_done"}, real'(done), 0.0);
      chk({name, "_best_code"}, real'(best_code), 0.0);
      chk({name, "_best_open"}, best_opening, 0.0);
      chk({name, "_timeout"}, real'(timeout_err), 0.0);
   endtask

   task automatic fill_linear(input real base, input real step);
      for (int c = 0; c < 16; c++) begin
         tbl_a[c] = base + step * c;
         tbl_b[c] = tbl_a[c];
      end
   endtask

   initial begin
      int dc;

      #1;
      check_reset("reset");
      @(negedge clock);
      @(negedge clock);
      reset = 1'b1;
      repeat (2) @(negedge clock);

      // Peak of 0.90 at code 7 over a 0.10..0.85 ramp
      fill_linear(0.10, 0.05);
      tbl_a[7] = 0.90; tbl_b[7] = 0.90;
      sweep_start(1'b0);
      chk("busy_sweep", real'(busy), 1.0);
      run_codes(15, 1'b0);
      wait_done(4);
      check_result("peak7", 7, 0.90, 1'b0);

      // Tie at 0.80 between codes 3 and 9: lower code wins
      fill_linear(0.10, 0.01);
      tbl_a[3] = 0.80; tbl_b[3] = 0.80;
      tbl_a[9] = 0.80; tbl_b[9] = 0.80;
      sweep_start(1'b0);
      run_codes(15, 1'b0);
      wait_done(4);
      check_result("tie", 3, 0.80, 1'b0);

      // Stray 9.99 pulses at start, in SETTLE, on FLUSH entry and on the flushed window
      fill_linear(0.10, 0.05);
      sweep_start(1'b1);
      run_codes(15, 1'b1);
      wait_done(4);
      check_result("noise", 15, 0.85, 1'b0);

      // Measurement stops answering after code 5
      fill_linear(0.90, 0.0);
      tbl_a[0] = 0.2; tbl_a[1] = 0.3; tbl_a[2] = 0.7;
      tbl_a[3] = 0.4; tbl_a[4] = 0.6; tbl_a[5] = 0.5;
      for (int c = 0; c < 16; c++) tbl_b[c] = tbl_a[c];
      sweep_start(1'b0);
      run_codes(5, 1'b0);
      wait_done(1200);
      check_result("timeout", 2, 0.7, 1'b1);

      // Reset in the middle of code 4, then a clean sweep
      fill_linear(0.10, 0.05);
      tbl_a[7] = 0.90; tbl_b[7] = 0.90;
      sweep_start(1'b0);
      run_codes(3, 1'b0);
      @(negedge clock);
      chk("tap_before_rst", real'(tap_code), 4.0);
      dc = done_cnt;
      reset = 1'b0;
      #1;
      check_reset("midreset");
      repeat (3) @(negedge clock);
      reset = 1'b1;
      repeat (5) @(negedge clock);
      chk("no_done_after_rst", real'(done_cnt), real'(dc));
      sweep_start(1'b0);
      run_codes(15, 1'b0);
      wait_done(4);
      check_result("resweep", 7, 0.90, 1'b0);

`ifdef EQ_SWEEP_AVG_EN
      // Averaged pair 0.4/0.6 at code 2 beats a steady 0.45 at code 5
      fill_linear(0.10, 0.0);
      tbl_a[2] = 0.4;  tbl_b[2] = 0.6;
      tbl_a[5] = 0.45; tbl_b[5] = 0.45;
      sweep_start(1'b0);
      run_codes(15, 1'b0);
      wait_done(4);
      check_result("avg", 2, 0.5, 1'b0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/eq_tap_sweep.md
EQ_TAP_SWEEP -- requirements
Module: eq_tap_sweep

Interface
REQ-001 SHALL have parameter TAP_BITS, default 4, the tap code width.
REQ-002 SHALL have parameter TAP_MAX, default 15, the last code swept; TAP_MAX SHALL be at most 2**TAP_BITS-1.
REQ-003 SHALL have parameter SETTLE_CYCLES, default 16, the cycles waited after each tap change.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 1024, the maximum wait for opening_ready.
REQ-005 SHALL have port clock, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit, asynchronous active-low reset.
REQ-007 SHALL have port start, input, 1 bit, a sweep request pulse.
REQ-008 SHALL have port opening, input, real, the eye opening from the eye measurement block.
REQ-009 SHALL have port opening_ready, input, 1 bit, a one-cycle pulse marking opening as valid.
REQ-010 SHALL have port tap_code, output, TAP_BITS, the equalizer tap driven to the TX FFE.
REQ-011 SHALL have port busy, output, 1 bit, high from sweep start until done.
REQ-012 SHALL have port done, output, 1 bit, a one-cycle sweep-complete pulse.
REQ-013 SHALL have port best_code, output, TAP_BITS, the code with the largest opening.
REQ-014 SHALL have port best_opening, output, real, the opening measured at best_code.
REQ-015 SHALL have port timeout_err, output, 1 bit, a sticky flag that the measurement did not respond.

Function
REQ-016 SHALL implement FSM states IDLE, APPLY, SETTLE, FLUSH, MEASURE, NEXT and FINISH.
REQ-017 In IDLE, SHALL ignore start while busy and accept start only in IDLE.
- On start: code := 0, best_opening := -1.0e30, timeout_err := 0, busy := 1, go to APPLY.
REQ-018 In APPLY, SHALL drive tap_code := code, clear the settle counter and go to SETTLE next cycle.
REQ-019 In SETTLE, SHALL count SETTLE_CYCLES clocks, ignore opening_ready, then go to FLUSH.
REQ-020 In FLUSH, SHALL discard the first opening_ready, because that window straddles the tap change, then go to MEASURE.
REQ-021 In MEASURE, SHALL take the next opening_ready value as the measurement for code.
REQ-022 In NEXT, SHALL update best when measurement > best_opening (strictly greater).
- On update: best_code := code, best_opening := measurement.
- Ties SHALL keep the lowest code.
REQ-023 After NEXT, SHALL go to FINISH if code == TAP_MAX, else code := code+1 and go to APPLY.
- code SHALL never wrap.
REQ-024 In FINISH, SHALL drive tap_code := best_code, pulse done for one cycle, clear busy and return to IDLE.
REQ-025 Timeout: the wait counter SHALL reset on entering FLUSH or MEASURE.
- If TIMEOUT_CYCLES clocks pass with no opening_ready: set timeout_err and go to FINISH, keeping the best found so far.
- If no code was measured, best_code SHALL be 0.
REQ-026 SHALL ignore an opening_ready that arrives in the same cycle as the state entry to FLUSH; it is not counted.
REQ-027 SHALL ignore start and opening_ready arriving together in IDLE except for start.
REQ-028 SHALL keep best_code, best_opening, timeout_err and tap_code stable between sweeps.
REQ-029 Sweep latency: done SHALL assert at most (TAP_MAX+1)*(2+SETTLE_CYCLES+2*TIMEOUT_CYCLES)+2 cycles after start.

Reset
REQ-030 On reset low, SHALL asynchronously set: state IDLE, tap_code 0, busy 0, done 0, best_code 0, best_opening 0.0, timeout_err 0, all counters 0.
REQ-031 Reset mid-sweep SHALL abandon the sweep without pulsing done.

Configuration
REQ-032 With EQ_SWEEP_AVG_EN defined, MEASURE SHALL collect two consecutive opening_ready values and use their mean as the measurement.
- The timeout counter SHALL restart after the first value.
REQ-033 Without EQ_SWEEP_AVG_EN, SHALL use a single value per code, as in REQ-021.

Structure
REQ-034 SHALL place the state enum type, the -1.0e30 initial-best constant and the default parameter values in package eq_sweep_pkg.
REQ-035 SHALL instantiate one sub-module, eq_wait_timer: a loadable down-counter with an expired flag, used for both settle and timeout.

Verification
REQ-036 Bench SHALL cover: openings 0.10+0.05*code except code 7 = 0.90 -> done, best_code 7, best_opening 0.90, tap_code 7.
REQ-037 Bench SHALL cover: code 3 and code 9 both 0.80 (maximum) -> best_code 3.
REQ-038 Bench SHALL cover: opening_ready stopped after code 5 is measured -> timeout_err 1, done pulses, best among codes 0..5.
REQ-039 Bench SHALL cover: opening_ready pulsed during SETTLE and the first FLUSH pulse carrying 9.99 -> both ignored, 9.99 never becomes best.
REQ-040 Bench SHALL cover: reset asserted at code 4 -> outputs at reset values, no done; a new start sweeps from code 0.
REQ-041 Bench SHALL cover: with EQ_SWEEP_AVG_EN, pairs 0.4/0.6 at code 2 versus a 0.45 peak elsewhere -> best_code 2, best_opening 0.5.
